// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send inhibit, start bit, shift-out of
// data/parity/stop on device clock falls, acknowledge check, and protocol timeouts.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_TIMEOUT    = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic       kb_clk_oe,
    output logic       kb_data_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int MAX_A     = (INHIBIT_CYCLES > REQ_TIMEOUT) ? INHIBIT_CYCLES : REQ_TIMEOUT;
    localparam int MAX_COUNT = (MAX_A > BIT_TIMEOUT) ? MAX_A : BIT_TIMEOUT;
    localparam int CNT_W     = $clog2(MAX_COUNT + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(BIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       ACK_EDGE_IDX = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_BITS,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic [9:0]       shift_q, shift_d;

    logic clk_meta_q, clk_meta_d;
    logic clk_sync_q, clk_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic data_meta_q, data_meta_d;
    logic data_sync_q, data_sync_d;

    logic clk_oe_q, clk_oe_d;
    logic data_oe_q, data_oe_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic error_q, error_d;

    logic             fall;
    logic [CNT_W-1:0] bit_limit;

    always_comb begin
        clk_meta_d  = kb_clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        data_meta_d = kb_data;
        data_sync_d = data_meta_q;
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    // Until the device has clocked once it gets the long request window.
    assign bit_limit = (idx_q == 4'd0) ? REQ_LAST : BIT_LAST;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_oe_d = data_oe_q;

        unique case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    shift_d = {1'b1, ~^tx_data, tx_data};
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_START: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = S_BITS;
            end

            S_BITS: begin
                if (fall) begin
                    cnt_d = '0;
                    if (idx_q == ACK_EDGE_IDX) begin
                        state_d = data_sync_q ? S_ERR : S_WAIT_IDLE;
                    end else begin
                        // Frame bit 9 is the stop bit (1), so edge 10 releases the line.
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[9:1]};
                        idx_d     = idx_q + 4'd1;
                    end
                end else if (cnt_q == bit_limit) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_WAIT_IDLE: begin
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_DONE;
                end else if (cnt_q == BIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so the pad enables never glitch.
        if (state_d == S_START) begin
            data_oe_d = 1'b1;
        end else if (state_d != S_BITS) begin
            data_oe_d = 1'b0;
        end

        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_START);
        busy_d   = (state_d == S_INHIBIT) || (state_d == S_START) ||
                   (state_d == S_BITS)    || (state_d == S_WAIT_IDLE);
        done_d   = (state_d == S_DONE);
        error_d  = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign kb_clk_oe  = clk_oe_q;
    assign kb_data_oe = data_oe_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the open-collector lines while a
// timeline model of the transfer predicts every output on every cycle.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int REQ  = 300;
    localparam int BIT  = 100;
    localparam int HALF = 8;
    localparam int INF  = 2147483647;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       kb_clk;
    logic       kb_data;
    logic       kb_clk_oe;
    logic       kb_data_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    // Open-collector lines: low if either side pulls.
    assign kb_clk  = dev_clk & ~kb_clk_oe;
    assign kb_data = dev_data & ~kb_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_TIMEOUT   (REQ),
        .BIT_TIMEOUT   (BIT)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .kb_clk    (kb_clk),
        .kb_data   (kb_data),
        .kb_clk_oe (kb_clk_oe),
        .kb_data_oe(kb_data_oe),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks      = 0;
    int         errors      = 0;
    bit         xfer        = 1'b0;
    int         acc_t       = 0;
    int         t_end       = INF;
    bit         end_is_done = 1'b0;
    logic [9:0] mframe      = '0;
    int         fall_t[$];
    int         clk_oe_cnt  = 0;
    int         err_cyc     = -1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Expected {clk_oe, data_oe, busy, done, error} from the transfer timeline:
    // accept, INH inhibit cycles, one start cycle, then bits until the end event.
    // A device line change becomes visible in DUT outputs three cycles later.
    task automatic cmp_cycle();
        logic [4:0] e;
        int nf;
        e = '0;
        if (kb_clk_oe) clk_oe_cnt++;
        if (tx_error) err_cyc = cyc;
        if (xfer && cyc > acc_t && cyc <= t_end) begin
            if (cyc == t_end) begin
                e = end_is_done ? 5'b00010 : 5'b00001;
            end else if (cyc <= acc_t + INH) begin
                e = 5'b10100;
            end else if (cyc == acc_t + INH + 1) begin
                e = 5'b11100;
            end else begin
                nf = 0;
                foreach (fall_t[i]) if (fall_t[i] + 3 <= cyc) nf++;
                e = 5'b00100;
                if (nf == 0) e[3] = 1'b1;
                else if (nf <= 9) e[3] = ~mframe[nf-1];
            end
        end
        check("outputs", 32'({kb_clk_oe, kb_data_oe, tx_busy, tx_done, tx_error}), 32'(e));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            cmp_cycle();
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic start_xfer(input logic [7:0] d);
        tx_data     = d;
        tx_start    = 1'b1;
        acc_t       = cyc;
        mframe      = {1'b1, (($countones(d) % 2) == 0) ? 1'b1 : 1'b0, d};
        fall_t.delete();
        t_end       = INF;
        end_is_done = 1'b0;
        xfer        = 1'b1;
        clk_oe_cnt  = 0;
        err_cyc     = -1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic pulse_start(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Device clocks nfalls pulses; samples the data line before the first fall (start)
    // and at every rising edge. With ack it pulls data low ahead of the 11th fall.
    task automatic dev_frame(input int nfalls, input bit ack, output logic [11:0] got);
        got    = '0;
        got[0] = kb_data;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk = 1'b0;
            fall_t.push_back(cyc);
            if (i == 11 && !ack) begin
                t_end       = cyc + 3;
                end_is_done = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            got[i]  = kb_data;
            if (i == 10 && ack) begin
                repeat (HALF / 2) @(negedge clk);
                dev_data = 1'b0;
                repeat (HALF / 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic ack_xfer(input logic [7:0] d, output logic [11:0] got);
        start_xfer(d);
        wait_until(acc_t + INH + 5);
        dev_frame(11, 1'b1, got);
        dev_data    = 1'b1;
        t_end       = cyc + 3;
        end_is_done = 1'b1;
        check("ack_frame", 32'(got), 32'({1'b0, mframe, 1'b0}));
    endtask

    initial begin
        logic [11:0] got;
        logic [7:0]  d;

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({kb_clk_oe, kb_data_oe, tx_busy, tx_done, tx_error}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED, with ignored re-requests in INHIBIT and in BITS
        start_xfer(8'hED);
        repeat (5) @(negedge clk);
        pulse_start(8'h55);
        wait_until(acc_t + INH + 5);
        pulse_start(8'h55);
        dev_frame(11, 1'b1, got);
        dev_data    = 1'b1;
        t_end       = cyc + 3;
        end_is_done = 1'b1;
        check("ed_frame", 32'(got), 32'({1'b0, 2'b11, 8'hED, 1'b0}));
        wait_until(t_end + 1);
        check("ed_clk_oe_cycles", 32'(clk_oe_cnt), 32'(INH + 1));

        ack_xfer(8'h00, got);
        check("zero_frame", 32'(got), 32'({1'b0, 2'b11, 8'h00, 1'b0}));

        // Each new request lands in the first cycle after the previous done pulse.
        for (int k = 0; k < 6; k++) begin
            wait_until(t_end + 1);
            d = 8'($urandom);
            ack_xfer(d, got);
            check("rand_parity", 32'($countones(got[9:1]) % 2), 32'(1));
        end
        wait_until(t_end + 5);

        // Device never clocks; a request during the error cycle must be ignored.
        start_xfer(8'($urandom));
        t_end       = acc_t + INH + 2 + REQ;
        end_is_done = 1'b0;
        wait_until(t_end);
        pulse_start(8'h55);
        wait_until(t_end + 5);
        check("req_timeout_cycle", 32'(err_cyc), 32'(acc_t + INH + 2 + REQ));

        // Device stops after edge 4.
        start_xfer(8'($urandom));
        wait_until(acc_t + INH + 5);
        dev_frame(4, 1'b0, got);
        t_end       = fall_t[3] + 3 + BIT;
        end_is_done = 1'b0;
        wait_until(t_end + 5);
        check("bit_timeout_cycle", 32'(err_cyc), 32'(fall_t[3] + 3 + BIT));

        // No acknowledge on edge 11.
        start_xfer(8'($urandom));
        wait_until(acc_t + INH + 5);
        dev_frame(11, 1'b0, got);
        check("noack_frame", 32'(got), 32'({1'b1, mframe, 1'b0}));
        wait_until(t_end + 5);
        check("noack_error_cycle", 32'(err_cyc), 32'(t_end));

        // Reset mid-BITS while the host is pulling data low (d2 of 0xA0 is 0).
        start_xfer(8'hA0);
        wait_until(acc_t + INH + 5);
        dev_frame(3, 1'b0, got);
        check("pre_reset_data_oe", 32'(kb_data_oe), 32'(1));
        #2;
        rst  = 1'b1;
        xfer = 1'b0;
        #1;
        check("async_reset", 32'({kb_clk_oe, kb_data_oe, tx_busy, tx_done, tx_error}), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (REQ / 2) @(negedge clk);

        ack_xfer(8'($urandom), got);
        wait_until(t_end + 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
